// File: rtl/transmitter_if.sv
// Serial transmitter handshake bundle: baud tick, FIFO side and serial/status outputs.
// The transmitter attaches through the slave modport; the driver side uses master.
interface transmitter_if #(
    parameter int SIZE_DATA = 8
);
    logic                 i_stick;
    logic                 i_tx_en;
    logic                 i_fifo_empty;
    logic [SIZE_DATA-1:0] i_tx_data;
    logic                 o_fifo_rd;
    logic                 o_tx_serial;
    logic                 o_tx_busy;
    logic                 o_tx_done;

    modport master (
        output i_stick, i_tx_en, i_fifo_empty, i_tx_data,
        input  o_fifo_rd, o_tx_serial, o_tx_busy, o_tx_done
    );

    modport slave (
        input  i_stick, i_tx_en, i_fifo_empty, i_tx_data,
        output o_fifo_rd, o_tx_serial, o_tx_busy, o_tx_done
    );
endinterface

// File: rtl/transmitter.sv
// UART-style serial transmitter: start bit, SIZE_DATA bits LSB first, optional even parity, one stop bit.
// Define UART_TX_PARITY_EN to add the parity bit; default build sends no parity.
module transmitter #(
    parameter int SIZE_DATA   = 8,
    parameter int OVER_SAMPLE = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    transmitter_if.slave  bus
);
    localparam int CW = $clog2(OVER_SAMPLE);
    localparam int IW = (SIZE_DATA > 1) ? $clog2(SIZE_DATA) : 1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd3;
`endif
    localparam logic [2:0] ST_STOP   = 3'd4;

    logic [2:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [SIZE_DATA-1:0] hold_q, hold_d;
    logic                 done_q, done_d;
    logic                 accept;
    logic                 bit_end;
    logic                 serial;

    // Reset is folded in so the pop strobe is low for the whole reset window.
    assign accept  = (state_q == ST_IDLE) & bus.i_tx_en & ~bus.i_fifo_empty & ~i_rst;
    assign bit_end = bus.i_stick & (cnt_q == CW'(OVER_SAMPLE - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        done_d  = 1'b0;
        if (accept) begin
            hold_d  = bus.i_tx_data;
            cnt_d   = '0;
            idx_d   = '0;
            state_d = ST_START;
        end else if (state_q != ST_IDLE && bus.i_stick) begin
            cnt_d = bit_end ? '0 : cnt_q + CW'(1);
            if (bit_end) begin
                case (state_q)
                    ST_START: begin
                        state_d = ST_DATA;
                        idx_d   = '0;
                    end
                    ST_DATA: begin
                        if (idx_q == IW'(SIZE_DATA - 1)) begin
`ifdef UART_TX_PARITY_EN
                            state_d = ST_PARITY;
`else
                            state_d = ST_STOP;
`endif
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    ST_PARITY: state_d = ST_STOP;
`endif
                    ST_STOP: begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    // Line level is a pure decode of registered state, so inputs never glitch the line.
    always_comb begin
        serial = 1'b1;
        case (state_q)
            ST_START:  serial = 1'b0;
            ST_DATA:   serial = hold_q[idx_q];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: serial = ^hold_q;
`endif
            default:   serial = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            hold_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
        end
    end

    assign bus.o_fifo_rd   = accept;
    assign bus.o_tx_serial = serial;
    assign bus.o_tx_busy   = (state_q != ST_IDLE);
    assign bus.o_tx_done   = done_q;
endmodule

// File: tb/tb_transmitter.sv
// Scoreboard bench for transmitter: words pushed to a FIFO model are queued as expected frames
// and a monitor checks every bit level/length, the done pulse and idle behaviour.
module tb_transmitter;
    localparam int SD = 8;
    localparam int OS = 16;

    logic i_clk = 1'b0;
    logic i_rst;

    transmitter_if #(.SIZE_DATA(SD)) tif ();
    transmitter #(.SIZE_DATA(SD), .OVER_SAMPLE(OS)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (tif)
    );

    always #5 i_clk = ~i_clk;

    int n_chk = 0, n_pass = 0;
    logic [SD-1:0] fifo_q[$];
    logic [SD-1:0] exp_q[$];
    int stick_per = 1;
    int cyc = 0;
    int rd_cnt = 0, frames = 0, stray_done = 0, idle_bad = 0, b2b = 0;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d want %0d", tag, act, exp);
    endtask

    task automatic drive_in();
        tif.i_stick      = (cyc % stick_per == 0);
        tif.i_fifo_empty = (fifo_q.size() == 0);
        tif.i_tx_data    = tif.i_fifo_empty ? SD'($urandom) : fifo_q[0];
    endtask

    task automatic step();
        logic rd;
        @(negedge i_clk);
        rd = tif.o_fifo_rd;
        @(posedge i_clk);
        #1;
        if (rd === 1'b1 && fifo_q.size() > 0) void'(fifo_q.pop_front());
        cyc++;
        drive_in();
    endtask

    task automatic push(input logic [SD-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
        drive_in();
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(fifo_q.size() == 0 && exp_q.size() == 0 &&
                 tif.o_tx_busy === 1'b0 && tif.o_tx_done === 1'b0) && n < 3000) begin
            step();
            n++;
        end
        if (n >= 3000) chk("wait_idle_timeout", 0, 1);
        step();
    endtask

    // Called at the negedge of the pop cycle; returns at the negedge of the done cycle.
    task automatic check_frame();
        logic [SD-1:0] w;
        logic          bits [0:SD+2];
        int            nb;
        rd_cnt++;
        if (exp_q.size() == 0) begin
            chk("sb_underflow", 0, 1);
            w = '0;
        end else begin
            w = exp_q.pop_front();
        end
        bits[0] = 1'b0;
        for (int i = 0; i < SD; i++) bits[i+1] = w[i];
`ifdef UART_TX_PARITY_EN
        bits[SD+1] = ^w;
        nb = SD + 3;
`else
        nb = SD + 2;
`endif
        bits[nb-1] = 1'b1;
        for (int b = 0; b < nb; b++) begin
            int dur = 0, bad = 0, st = 0;
            while (st < OS && dur < OS * stick_per + 8) begin
                @(negedge i_clk);
                if (i_rst) return;
                dur++;
                if (tif.o_tx_serial !== bits[b] || tif.o_tx_busy !== 1'b1 ||
                    tif.o_tx_done !== 1'b0 || tif.o_fifo_rd !== 1'b0) bad++;
                if (tif.i_stick) st++;
            end
            chk($sformatf("w%02h_bit%0d_lvl", w, b), bad, 0);
            chk($sformatf("w%02h_bit%0d_len", w, b), dur, OS * stick_per);
        end
        @(negedge i_clk);
        if (i_rst) return;
        chk($sformatf("w%02h_done", w), int'(tif.o_tx_done), 1);
        chk($sformatf("w%02h_end_busy", w), int'(tif.o_tx_busy), 0);
        chk($sformatf("w%02h_end_line", w), int'(tif.o_tx_serial), 1);
        frames++;
    endtask

    initial begin
        int k;
        forever begin
            @(negedge i_clk);
            k = 0;
            while (i_rst === 1'b0 && tif.o_fifo_rd === 1'b1) begin
                if (k > 0) b2b++;
                check_frame();
                k++;
            end
            if (k == 0 && i_rst === 1'b0) begin
                if (tif.o_tx_done !== 1'b0) stray_done++;
                if (tif.o_tx_serial !== 1'b1 || tif.o_tx_busy !== 1'b0) idle_bad++;
            end
        end
    end

    initial begin
        int r0, f0, b0;
        i_rst = 1'b0;
        tif.i_tx_en = 1'b1;
        drive_in();
        #1 i_rst = 1'b1;
        push(8'h3C);
        #2;
        chk("rst_line", int'(tif.o_tx_serial), 1);
        chk("rst_busy", int'(tif.o_tx_busy), 0);
        chk("rst_rd", int'(tif.o_fifo_rd), 0);
        chk("rst_done", int'(tif.o_tx_done), 0);
        repeat (3) step();
        i_rst = 1'b0;
        wait_idle();

        push(8'hA5);
        wait_idle();

        // Two queued words: the second pop must land on the first done cycle.
        tif.i_tx_en = 1'b0;
        push(8'h55);
        push(8'h0F);
        b0 = b2b;
        tif.i_tx_en = 1'b1;
        wait_idle();
        chk("b2b_pop_on_done", b2b - b0, 1);

        // Slow tick: accept on a tick cycle so every bit spans 64 clocks.
        stick_per = 4;
        tif.i_tx_en = 1'b0;
        drive_in();
        push(8'hC3);
        step();
        while (cyc % 4 != 0) step();
        tif.i_tx_en = 1'b1;
        wait_idle();
        stick_per = 1;
        drive_in();

        // Reset 40 cycles into a frame.
        f0 = frames;
        push(8'hA5);
        repeat (40) step();
        i_rst = 1'b1;
        #1;
        chk("abort_line", int'(tif.o_tx_serial), 1);
        chk("abort_busy", int'(tif.o_tx_busy), 0);
        chk("abort_done", int'(tif.o_tx_done), 0);
        step();
        i_rst = 1'b0;
        repeat (20) step();
        chk("abort_no_frame", frames - f0, 0);
        push(8'h96);
        wait_idle();

        // Disabled with data waiting, then enable and drop mid-frame.
        tif.i_tx_en = 1'b0;
        push(8'h81);
        r0 = rd_cnt;
        repeat (100) step();
        chk("dis_no_rd", rd_cnt - r0, 0);
        chk("dis_line", int'(tif.o_tx_serial), 1);
        tif.i_tx_en = 1'b1;
        repeat (20) step();
        tif.i_tx_en = 1'b0;
        wait_idle();
        chk("dis_frame_sent", rd_cnt - r0, 1);

        tif.i_tx_en = 1'b1;
        push(8'h07);
        push(8'($urandom));
        push(8'($urandom));
        wait_idle();

        chk("sb_left", exp_q.size(), 0);
        chk("stray_done", stray_done, 0);
        chk("idle_bad", idle_bad, 0);
        chk("frames", frames, 10);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
